// File: rtl/feature_stream_source.sv
// Streams one stored image plus per-feature weights and a bias word to the classifier, then captures its result.
// Optional macro BIAS_HANDSHAKE_EN: the bias stream obeys b_tready instead of being held valid through STREAM.
module feature_stream_source #(
  parameter int NUM_CLASSES    = 10,
  parameter int INPUT_FEATURES = 160,
  parameter int X_WIDTH        = 4,
  parameter int W_WIDTH        = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int AW = $clog2(INPUT_FEATURES),
  localparam int BW = NUM_CLASSES * W_WIDTH
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [3:0]         result,
  output logic [15:0]        result_raw,
  input  logic               img_we,
  input  logic [AW-1:0]      img_waddr,
  input  logic [X_WIDTH-1:0] img_wdata,
  input  logic               wgt_we,
  input  logic [AW-1:0]      wgt_waddr,
  input  logic [BW-1:0]      wgt_wdata,
  input  logic               bias_we,
  input  logic [BW-1:0]      bias_wdata,
  output logic [X_WIDTH-1:0] x_tdata,
  output logic               x_tvalid,
  input  logic               x_tready,
  output logic [BW-1:0]      w_tdata,
  output logic               w_tvalid,
  input  logic               w_tready,
  output logic [BW-1:0]      b_tdata,
  output logic               b_tvalid,
  input  logic               b_tready,
  input  logic [3:0]         a_tdata,
  input  logic [15:0]        raw,
  input  logic               a_tvalid,
  output logic               a_tready
);

  localparam int KW = $clog2(INPUT_FEATURES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [KW-1:0] KN    = KW'(INPUT_FEATURES);
  localparam logic [KW-1:0] KLAST = KW'(INPUT_FEATURES - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PREFETCH, STREAM, WAIT_RESULT} state_t;

  state_t state, state_next;

  logic [X_WIDTH-1:0] img_mem [INPUT_FEATURES];
  logic [BW-1:0]      wgt_mem [INPUT_FEATURES];
  logic [BW-1:0]      bias_reg;
  logic [X_WIDTH-1:0] img_q;
  logic [BW-1:0]      wgt_q;

  logic [KW-1:0] k;
  logic [KW-1:0] rd_addr;
  logic [TW-1:0] tcount;
  logic          xw_valid;
  logic          beat;
  logic          bias_complete;
  logic          a_fire;
  logic          expire;
`ifdef BIAS_HANDSHAKE_EN
  logic          bias_done;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next    = state;
    xw_valid      = 1'b0;
    b_tvalid      = 1'b0;
    a_tready      = 1'b0;
    beat          = 1'b0;
    bias_complete = 1'b0;
    a_fire        = 1'b0;
    expire        = 1'b0;
    unique case (state)
      IDLE: if (start) state_next = PREFETCH;
      PREFETCH: state_next = STREAM;
      STREAM: begin
        xw_valid = (k < KN);
        beat     = xw_valid & x_tready & w_tready;
`ifdef BIAS_HANDSHAKE_EN
        b_tvalid      = ~bias_done;
        bias_complete = bias_done | b_tready;
`else
        b_tvalid      = 1'b1;
        bias_complete = 1'b1;
`endif
        if (((k == KN) || (beat && (k == KLAST))) && bias_complete)
          state_next = WAIT_RESULT;
      end
      WAIT_RESULT: begin
        a_tready = 1'b1;
        a_fire   = a_tvalid;
        expire   = (tcount == TLAST);
        if (a_fire || expire) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign x_tvalid = xw_valid;
  assign w_tvalid = xw_valid;
  assign x_tdata  = xw_valid ? img_q : '0;
  assign w_tdata  = xw_valid ? wgt_q : '0;
  assign b_tdata  = b_tvalid ? bias_reg : '0;

  // Look one entry ahead on a beat so the next beat's data lands without a bubble.
  assign rd_addr = beat ? (k + 1'b1) : k;

  // Loader writes only land while idle; memories and bias deliberately have no reset.
  always_ff @(posedge CLK) begin
    if (img_we && !busy && (img_waddr < AW'(INPUT_FEATURES))) img_mem[img_waddr] <= img_wdata;
    if (wgt_we && !busy && (wgt_waddr < AW'(INPUT_FEATURES))) wgt_mem[wgt_waddr] <= wgt_wdata;
    if (bias_we && !busy) bias_reg <= bias_wdata;
    if (rd_addr < KN) begin
      img_q <= img_mem[rd_addr[AW-1:0]];
      wgt_q <= wgt_mem[rd_addr[AW-1:0]];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      k          <= '0;
      tcount     <= '0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      result     <= '0;
      result_raw <= '0;
`ifdef BIAS_HANDSHAKE_EN
      bias_done  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if ((state == IDLE) && start) begin
        k       <= '0;
        timeout <= 1'b0;
`ifdef BIAS_HANDSHAKE_EN
        bias_done <= 1'b0;
`endif
      end
      if (beat) k <= k + 1'b1;
`ifdef BIAS_HANDSHAKE_EN
      if (b_tvalid && b_tready) bias_done <= 1'b1;
`endif
      tcount <= (state == WAIT_RESULT) ? tcount + 1'b1 : '0;
      // A result arriving on the expiry cycle takes precedence over the timeout.
      if (a_fire) begin
        result     <= a_tdata;
        result_raw <= raw;
        done       <= 1'b1;
      end else if (expire) begin
        timeout <= 1'b1;
        done    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_feature_stream_source.sv
// Scoreboard bench for feature_stream_source: expected beats/results queued at stimulus, checked by a monitor.
module tb_feature_stream_source;

  localparam int NF = 160;
  localparam int BW = 40;
  localparam int TO = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, timeout;
  logic [3:0]    result;
  logic [15:0]   result_raw;
  logic          img_we = 1'b0;
  logic [7:0]    img_waddr = '0;
  logic [3:0]    img_wdata = '0;
  logic          wgt_we = 1'b0;
  logic [7:0]    wgt_waddr = '0;
  logic [BW-1:0] wgt_wdata = '0;
  logic          bias_we = 1'b0;
  logic [BW-1:0] bias_wdata = '0;
  logic [3:0]    x_tdata;
  logic          x_tvalid;
  logic          x_tready = 1'b1;
  logic [BW-1:0] w_tdata;
  logic          w_tvalid;
  logic          w_tready = 1'b1;
  logic [BW-1:0] b_tdata;
  logic          b_tvalid;
  logic          b_tready = 1'b1;
  logic [3:0]    a_tdata = '0;
  logic [15:0]   raw = '0;
  logic          a_tvalid = 1'b0;
  logic          a_tready;

  feature_stream_source #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST), .start(start), .busy(busy), .done(done), .timeout(timeout),
    .result(result), .result_raw(result_raw),
    .img_we(img_we), .img_waddr(img_waddr), .img_wdata(img_wdata),
    .wgt_we(wgt_we), .wgt_waddr(wgt_waddr), .wgt_wdata(wgt_wdata),
    .bias_we(bias_we), .bias_wdata(bias_wdata),
    .x_tdata(x_tdata), .x_tvalid(x_tvalid), .x_tready(x_tready),
    .w_tdata(w_tdata), .w_tvalid(w_tvalid), .w_tready(w_tready),
    .b_tdata(b_tdata), .b_tvalid(b_tvalid), .b_tready(b_tready),
    .a_tdata(a_tdata), .raw(raw), .a_tvalid(a_tvalid), .a_tready(a_tready)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  res;
    logic [15:0] rw;
    logic        to;
  } res_t;

  logic [3:0]    img_ref [NF];
  logic [BW-1:0] wgt_ref [NF];
  logic [BW-1:0] bias_ref = '0;
  logic [3:0]    exp_result = '0;
  logic [15:0]   exp_raw = '0;

  logic [3:0]    exp_x_q [$];
  logic [BW-1:0] exp_w_q [$];
  res_t          res_q [$];
  int            beat_cyc [$];

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int beat_cnt = 0;
  int done_cnt = 0;
  int done_cycle = 0;
  int bias_beat_cycle = 0;
  int base = 0;
  int start_cycle = 0;
  int rmode = 0;
  bit bias_block = 1'b0;

  bit            hold = 1'b0;
  logic [3:0]    hold_x;
  logic [BW-1:0] hold_w;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  always @(posedge CLK) cycle++;

  // Ready generator: selectable back-pressure patterns on the x/w/b streams.
  always @(posedge CLK) begin
    #1;
    case (rmode)
      1: begin x_tready = 1'b1; w_tready = (cycle % 3) != 0; end
      2: begin x_tready = ($urandom % 4) != 0; w_tready = ($urandom % 4) != 0; end
      default: begin x_tready = 1'b1; w_tready = 1'b1; end
    endcase
    b_tready = bias_block ? 1'b0 : ((rmode == 0) ? 1'b1 : 1'($urandom % 2));
  end

  // Monitor: pops expected beats and results whenever the DUT presents them.
  always @(negedge CLK) begin
    if (!RST) begin
      hold = 1'b0;
    end else begin
      if (x_tvalid || w_tvalid) check("xw_valid_pair", 64'(w_tvalid), 64'(x_tvalid));
      if (x_tvalid) begin
        if (hold) begin
          check("x_stable", 64'(x_tdata), 64'(hold_x));
          check("w_stable", 64'(w_tdata), 64'(hold_w));
        end
        if (x_tready && w_tready) begin
          if (exp_x_q.size() == 0) begin
            check("extra_beat", 64'(beat_cnt - base), 64'(NF));
          end else begin
            check("x_data", 64'(x_tdata), 64'(exp_x_q.pop_front()));
            check("w_data", 64'(w_tdata), 64'(exp_w_q.pop_front()));
          end
          beat_cnt++;
          beat_cyc.push_back(cycle);
          hold = 1'b0;
        end else begin
          hold   = 1'b1;
          hold_x = x_tdata;
          hold_w = w_tdata;
        end
      end else if (hold) begin
        check("valid_withdrawn", 64'(x_tvalid), 64'(1));
        hold = 1'b0;
      end
      if (b_tvalid) check("b_data", 64'(b_tdata), 64'(bias_ref));
      if (b_tvalid && b_tready) bias_beat_cycle = cycle;
      if (done) begin
        done_cnt++;
        done_cycle = cycle;
        if (res_q.size() == 0) begin
          check("unexpected_done", 64'(done), 64'(0));
        end else begin
          res_t r;
          r = res_q.pop_front();
          check("result", 64'(result), 64'(r.res));
          check("result_raw", 64'(result_raw), 64'(r.rw));
          check("timeout_flag", 64'(timeout), 64'(r.to));
          check("busy_at_done", 64'(busy), 64'(0));
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_mem(input bit rnd);
    for (int k = 0; k < NF; k++) begin
      img_we    = 1'b1;
      wgt_we    = 1'b1;
      img_waddr = 8'(k);
      wgt_waddr = 8'(k);
      img_wdata = rnd ? 4'($urandom) : 4'(k % 16);
      wgt_wdata = rnd ? {8'($urandom), 32'($urandom)} : BW'(k);
      img_ref[k] = img_wdata;
      wgt_ref[k] = wgt_wdata;
      tick();
    end
    img_we     = 1'b0;
    wgt_we     = 1'b0;
    bias_we    = 1'b1;
    bias_wdata = rnd ? {8'($urandom), 32'($urandom)} : 40'h0123456789;
    bias_ref   = bias_wdata;
    tick();
    bias_we = 1'b0;
  endtask

  task automatic start_run();
    exp_x_q.delete();
    exp_w_q.delete();
    for (int k = 0; k < NF; k++) begin
      exp_x_q.push_back(img_ref[k]);
      exp_w_q.push_back(wgt_ref[k]);
    end
    base        = beat_cnt;
    start       = 1'b1;
    start_cycle = cycle;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n = 0;
    while ((beat_cnt - base) < target && n < budget) begin
      tick();
      n++;
    end
    if ((beat_cnt - base) < target) check("beat_wait", 64'(beat_cnt - base), 64'(target));
  endtask

  task automatic wait_a_ready(input int budget);
    int n = 0;
    while (!a_tready && n < budget) begin
      tick();
      n++;
    end
    if (!a_tready) check("a_ready_wait", 64'(a_tready), 64'(1));
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt < target) check("done_wait", 64'(done_cnt), 64'(target));
  endtask

  task automatic finish_with_result(input logic [3:0] r, input logic [15:0] rw);
    a_tdata  = r;
    raw      = rw;
    a_tvalid = 1'b1;
    wait_a_ready(4000);
    res_q.push_back('{res: r, rw: rw, to: 1'b0});
    exp_result = r;
    exp_raw    = rw;
    tick();
    a_tvalid = 1'b0;
    check("done_after_handshake", 64'(done), 64'(1));
    check("busy_after_handshake", 64'(busy), 64'(0));
    tick();
    check("done_pulse_width", 64'(done), 64'(0));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_timeout"}, 64'(timeout), 64'(0));
    check({tag, "_result"}, 64'(result), 64'(0));
    check({tag, "_raw"}, 64'(result_raw), 64'(0));
    check({tag, "_xw_valid"}, 64'({x_tvalid, w_tvalid}), 64'(0));
    check({tag, "_b_valid"}, 64'(b_tvalid), 64'(0));
    check({tag, "_a_ready"}, 64'(a_tready), 64'(0));
    check({tag, "_tdata"}, 64'({x_tdata, w_tdata[19:0]}), 64'(0));
    check({tag, "_b_tdata"}, 64'(b_tdata), 64'(0));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int entry;
    repeat (3) @(negedge CLK);
    check_reset_values("reset");
    @(posedge CLK);
    #1;
    RST = 1'b1;
    tick();

    // Directed image, full throughput, known result.
    rmode = 0;
    load_mem(1'b0);
    start_run();
    wait_beats(NF, 400);
    check("first_beat_latency", 64'(beat_cyc[base] - start_cycle), 64'(2));
    check("full_throughput", 64'(beat_cyc[base + NF - 1] - beat_cyc[base]), 64'(NF - 1));
    finish_with_result(4'd7, 16'h0123);
    check("timeout_clear", 64'(timeout), 64'(0));

    // No result: timeout after TO cycles in WAIT_RESULT, prior result retained.
    start_run();
    wait_beats(NF, 400);
    wait_a_ready(50);
    entry = cycle;
    res_q.push_back('{res: exp_result, rw: exp_raw, to: 1'b1});
    wait_done(2, 60);
    check("timeout_latency", 64'(done_cycle - entry), 64'(TO));
    tick();
    tick();
    check("timeout_sticky", 64'(timeout), 64'(1));
    load_mem(1'b1);
    start_run();
    check("timeout_cleared_by_start", 64'(timeout), 64'(0));
    wait_beats(NF, 400);
    finish_with_result(4'($urandom), 16'($urandom));

    // Random data with back-pressure; loader writes and start while busy must be dropped.
    for (int run = 0; run < 3; run++) begin
      int a;
      rmode = (run == 0) ? 1 : 2;
      load_mem(1'b1);
      start_run();
      repeat (5) tick();
      a = $urandom_range(0, NF - 1);
      img_we     = 1'b1; img_waddr = 8'(a); img_wdata = ~img_ref[a];
      wgt_we     = 1'b1; wgt_waddr = 8'(a); wgt_wdata = ~wgt_ref[a];
      bias_we    = 1'b1; bias_wdata = ~bias_ref;
      start      = 1'b1;
      a_tvalid   = 1'b1;
      a_tdata    = 4'($urandom);
      raw        = 16'($urandom);
      tick();
      img_we = 1'b0; wgt_we = 1'b0; bias_we = 1'b0; start = 1'b0;
      wait_beats(NF, 2000);
      check("beat_count", 64'(beat_cnt - base), 64'(NF));
      finish_with_result(a_tdata, raw);
    end

    // Reset mid-stream at beat 50, then restart from beat 0 with memories intact.
    rmode = 0;
    start_run();
    wait_beats(50, 200);
    #2;
    RST = 1'b0;
    #1;
    check_reset_values("midreset");
    exp_result = '0;
    exp_raw    = '0;
    @(negedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    tick();
    start_run();
    wait_beats(NF, 400);
    check("restart_latency", 64'(beat_cyc[base] - start_cycle), 64'(2));
    finish_with_result(4'($urandom), 16'($urandom));

`ifdef BIAS_HANDSHAKE_EN
    // Bias held back: no WAIT_RESULT until the bias beat completes.
    bias_block = 1'b1;
    tick();
    start_run();
    wait_beats(NF, 400);
    repeat (5) tick();
    check("bias_block_a_ready", 64'(a_tready), 64'(0));
    check("bias_block_busy", 64'(busy), 64'(1));
    check("bias_block_b_valid", 64'(b_tvalid), 64'(1));
    bias_block = 1'b0;
    wait_a_ready(20);
    check("bias_to_a_ready", 64'(cycle - bias_beat_cycle), 64'(1));
    check("bias_valid_dropped", 64'(b_tvalid), 64'(0));
    finish_with_result(4'($urandom), 16'($urandom));
`endif

    repeat (3) tick();
    check("results_drained", 64'(res_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
